// File: rtl/booth8_mult_pipe_if.sv
// Operand/result valid-ready bundle for the pipelined radix-8 Booth multiplier.
interface booth8_mult_pipe_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned TAG_W = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_signed;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic [TAG_W-1:0]     in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_product;
  logic [TAG_W-1:0]     out_tag;

  // Issue side: drives operands and accepts results.
  modport master (
    output in_valid, in_signed, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_product, out_tag
  );

  // Multiplier side.
  modport slave (
    input  in_valid, in_signed, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_product, out_tag
  );
endinterface

// File: rtl/booth8_mult_pipe.sv
// Three-stage radix-8 Booth multiplier: S1 recode + partial products,
// S2 carry-save reduction, S3 carry-propagate add. Global-stall pipeline.
module booth8_mult_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  booth8_mult_pipe_if.slave bus
);
  localparam int unsigned PW = 2 * WIDTH;       // product width
  localparam int unsigned NG = (WIDTH + 4) / 3; // ceil((WIDTH+2)/3) Booth groups
  localparam int unsigned BW = 3 * NG + 1;      // padded multiplier incl. trailing 0

  logic              w_adv;
  logic [PW-1:0]     w_a1;
  logic [PW-1:0]     w_a3;
  logic [BW-1:0]     w_bx;
  logic [PW-1:0]     w_pp [NG];
  logic [PW-1:0]     w_sum;
  logic [PW-1:0]     w_carry;

  logic              r_v1;
  logic [PW-1:0]     r_pp [NG];
  logic [TAG_W-1:0]  r_tag1;
  logic              r_v2;
  logic [PW-1:0]     r_sum;
  logic [PW-1:0]     r_carry;
  logic [TAG_W-1:0]  r_tag2;
  logic              r_v3;
  logic [PW-1:0]     r_prod;
  logic [TAG_W-1:0]  r_tag3;

  // Whole pipeline moves together unless a held result blocks the output.
  assign w_adv           = !r_v3 || bus.out_ready;
  assign bus.in_ready    = w_adv;
  assign bus.out_valid   = r_v3;
  assign bus.out_product = r_prod;
  assign bus.out_tag     = r_tag3;

  // Mode-dependent extension of both operands; 3A is the only hard multiple.
  assign w_a1 = {{WIDTH{bus.in_signed & bus.in_a[WIDTH-1]}}, bus.in_a};
  assign w_a3 = w_a1 + (w_a1 << 1);
  assign w_bx = {{(BW - WIDTH - 1){bus.in_signed & bus.in_b[WIDTH-1]}}, bus.in_b, 1'b0};

  // Recode each overlapping 4-bit window to a digit in -4..+4 and weight it.
  always_comb begin
    logic [3:0]    v_win;
    logic [PW-1:0] v_mag;
    v_win = '0;
    v_mag = '0;
    for (int unsigned i = 0; i < NG; i++) begin
      v_win = w_bx[3*i +: 4];
      case (v_win)
        4'b0001, 4'b0010, 4'b1101, 4'b1110: v_mag = w_a1;
        4'b0011, 4'b0100, 4'b1011, 4'b1100: v_mag = w_a1 << 1;
        4'b0101, 4'b0110, 4'b1001, 4'b1010: v_mag = w_a3;
        4'b0111, 4'b1000:                   v_mag = w_a1 << 2;
        default:                            v_mag = '0;
      endcase
      // Window MSB set means a negative digit (-0 for 1111 stays zero).
      if (v_win[3]) begin
        w_pp[i] = (~v_mag + PW'(1)) << (3*i);
      end else begin
        w_pp[i] = v_mag << (3*i);
      end
    end
  end

  // Carry-save chain of 3:2 compressors over the registered partial products.
  always_comb begin
    logic [PW-1:0] v_s;
    logic [PW-1:0] v_c;
    logic [PW-1:0] v_t;
    v_s = r_pp[0];
    v_c = r_pp[1];
    v_t = '0;
    for (int unsigned i = 2; i < NG; i++) begin
      v_t = v_s ^ v_c ^ r_pp[i];
      v_c = ((v_s & v_c) | (v_s & r_pp[i]) | (v_c & r_pp[i])) << 1;
      v_s = v_t;
    end
    w_sum   = v_s;
    w_carry = v_c;
  end

  // Stage valid bits and the visible result; only real results reach the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_v3   <= 1'b0;
      r_prod <= '0;
      r_tag3 <= '0;
    end else if (w_adv) begin
      r_v1 <= bus.in_valid;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
      if (r_v2) begin
        r_prod <= r_sum + r_carry;
        r_tag3 <= r_tag2;
      end
    end
  end

  // Internal datapath registers; contents of bubbles are never observed.
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_pp    <= w_pp;
      r_tag1  <= bus.in_tag;
      r_sum   <= w_sum;
      r_carry <= w_carry;
      r_tag2  <= r_tag1;
    end
  end
endmodule

// File: tb/tb_booth8_mult_pipe.sv
// Scoreboard bench for booth8_mult_pipe: WIDTH=16 directed/random/stall/reset
// scenarios plus side instances at WIDTH=4 (exhaustive), 8, 13 and 32 (random).
module tb_booth8_mult_pipe;
  typedef struct {
    logic [63:0] prod;
    logic [3:0]  tag;
    int          acc;
    bit          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic rst_sw_n = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   tmo_cnt = 0;
  logic [3:0] tagc = '0;
  bit   lat_mode = 1'b0;
  bit   fin_req = 1'b0;
  logic [1:0] exp_ir = 2'd0; // 1: in_ready must be 0, 2: in_ready must be 1

  exp_t q_m[$];
  exp_t q4[$];
  exp_t q8[$];
  exp_t q13[$];
  exp_t q32[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  booth8_mult_pipe_if #(.WIDTH(16), .TAG_W(4)) m_if ();
  booth8_mult_pipe #(.WIDTH(16), .TAG_W(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m_if)
  );

  // Exact product from plain integer arithmetic, truncated to 2*w bits.
  function automatic logic [63:0] ref_mul(input int unsigned w, input logic s,
                                          input logic [63:0] a, input logic [63:0] b);
    longint      sa;
    longint      sb;
    logic [63:0] m;
    logic [63:0] p;
    m  = (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    sa = longint'(a & m);
    sb = longint'(b & m);
    if (s && a[w-1]) sa = sa - (longint'(1) << w);
    if (s && b[w-1]) sb = sb - (longint'(1) << w);
    p = 64'(sa * sb);
    if (2 * w < 64) p = p & ((64'd1 << (2 * w)) - 64'd1);
    return p;
  endfunction

  function automatic logic [63:0] rnd_op(input int unsigned w);
    logic [63:0] m;
    logic [63:0] v;
    m = (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = m;
      2:       v = 64'd1 << (w - 1);
      3:       v = m >> 1;
      default: v = {$urandom, $urandom};
    endcase
    return v & m;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Parameter sweep instances on their own reset, always ready downstream.
  for (genvar gi = 0; gi < 4; gi++) begin : g_sw
    localparam int unsigned W = (gi == 0) ? 4 : (gi == 1) ? 8 : (gi == 2) ? 13 : 32;
    localparam int NOPS = (W == 4) ? 512 : 10000;
    bit done = 1'b0;
    int tmo = 0;
    booth8_mult_pipe_if #(.WIDTH(W), .TAG_W(4)) sw_if ();
    booth8_mult_pipe #(.WIDTH(W), .TAG_W(4)) u_sw (
      .clk   (clk),
      .rst_n (rst_sw_n),
      .bus   (sw_if)
    );

    initial begin
      exp_t        e;
      logic        s;
      logic [63:0] a;
      logic [63:0] b;
      bit          ok;
      sw_if.in_valid  = 1'b0;
      sw_if.in_signed = 1'b0;
      sw_if.in_a      = '0;
      sw_if.in_b      = '0;
      sw_if.in_tag    = '0;
      sw_if.out_ready = 1'b1;
      #20;
      wait (rst_sw_n === 1'b1);
      @(posedge clk); #1;
      for (int i = 0; i < NOPS; i++) begin
        if (W == 4) begin
          s = i[8];
          a = 64'(i[7:4]);
          b = 64'(i[3:0]);
        end else begin
          s = 1'($urandom_range(0, 1));
          a = rnd_op(W);
          b = rnd_op(W);
          if ($urandom_range(0, 7) == 0) begin
            sw_if.in_valid = 1'b0;
            sw_if.in_a     = W'($urandom);
            @(posedge clk); #1;
          end
        end
        sw_if.in_valid  = 1'b1;
        sw_if.in_signed = s;
        sw_if.in_a      = W'(a);
        sw_if.in_b      = W'(b);
        sw_if.in_tag    = 4'(i);
        e.prod = ref_mul(W, s, a, b);
        e.tag  = 4'(i);
        e.lat  = 1'b1;
        ok     = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
          @(negedge clk);
          if (sw_if.in_ready) begin
            ok    = 1'b1;
            e.acc = cyc;
            case (gi)
              0:       q4.push_back(e);
              1:       q8.push_back(e);
              2:       q13.push_back(e);
              default: q32.push_back(e);
            endcase
          end
          @(posedge clk); #1;
        end
        if (!ok) tmo++;
      end
      sw_if.in_valid = 1'b0;
      done = 1'b1;
    end
  end

  // Monitor: every comparison in the bench happens here.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q_m.delete();
      chk("reset_out_valid", 64'(m_if.out_valid), 64'd0);
      chk("reset_out_product", 64'(m_if.out_product), 64'd0);
      chk("reset_out_tag", 64'(m_if.out_tag), 64'd0);
    end else begin
      chk("in_ready_rule", 64'(m_if.in_ready), 64'(!m_if.out_valid || m_if.out_ready));
      if (exp_ir == 2'd1) chk("stall_in_ready", 64'(m_if.in_ready), 64'd0);
      if (exp_ir == 2'd2) chk("post_reset_in_ready", 64'(m_if.in_ready), 64'd1);
      if (m_if.out_valid) begin
        if (q_m.size() == 0) begin
          chk("unexpected_result", 64'(m_if.out_valid), 64'd0);
        end else begin
          e = q_m[0];
          chk("product", 64'(m_if.out_product), e.prod);
          chk("tag", 64'(m_if.out_tag), 64'(e.tag));
          if (e.lat) chk("latency", 64'(cyc - e.acc), 64'd3);
          if (m_if.out_ready) void'(q_m.pop_front());
        end
      end
    end

    if (g_sw[0].sw_if.out_valid) begin
      if (q4.size() == 0) chk("w4_unexpected", 64'(g_sw[0].sw_if.out_valid), 64'd0);
      else begin
        e = q4.pop_front();
        chk("w4_product", 64'(g_sw[0].sw_if.out_product), e.prod);
        chk("w4_tag", 64'(g_sw[0].sw_if.out_tag), 64'(e.tag));
        chk("w4_latency", 64'(cyc - e.acc), 64'd3);
      end
    end
    if (g_sw[1].sw_if.out_valid) begin
      if (q8.size() == 0) chk("w8_unexpected", 64'(g_sw[1].sw_if.out_valid), 64'd0);
      else begin
        e = q8.pop_front();
        chk("w8_product", 64'(g_sw[1].sw_if.out_product), e.prod);
        chk("w8_tag", 64'(g_sw[1].sw_if.out_tag), 64'(e.tag));
      end
    end
    if (g_sw[2].sw_if.out_valid) begin
      if (q13.size() == 0) chk("w13_unexpected", 64'(g_sw[2].sw_if.out_valid), 64'd0);
      else begin
        e = q13.pop_front();
        chk("w13_product", 64'(g_sw[2].sw_if.out_product), e.prod);
        chk("w13_tag", 64'(g_sw[2].sw_if.out_tag), 64'(e.tag));
      end
    end
    if (g_sw[3].sw_if.out_valid) begin
      if (q32.size() == 0) chk("w32_unexpected", 64'(g_sw[3].sw_if.out_valid), 64'd0);
      else begin
        e = q32.pop_front();
        chk("w32_product", 64'(g_sw[3].sw_if.out_product), e.prod);
        chk("w32_tag", 64'(g_sw[3].sw_if.out_tag), 64'(e.tag));
      end
    end

    if (fin_req) begin
      chk("main_queue_drained", 64'(q_m.size()), 64'd0);
      chk("w4_queue_drained", 64'(q4.size()), 64'd0);
      chk("w8_queue_drained", 64'(q8.size()), 64'd0);
      chk("w13_queue_drained", 64'(q13.size()), 64'd0);
      chk("w32_queue_drained", 64'(q32.size()), 64'd0);
      chk("main_issue_timeouts", 64'(tmo_cnt), 64'd0);
      chk("sweep_issue_timeouts", 64'(g_sw[0].tmo + g_sw[1].tmo + g_sw[2].tmo + g_sw[3].tmo), 64'd0);
    end
  end

  // Present one operation until accepted; expected result queued at acceptance.
  task automatic issue(input logic s, input logic [15:0] a, input logic [15:0] b,
                       input bit use_k, input logic [63:0] k);
    exp_t e;
    bit   ok;
    m_if.in_valid  = 1'b1;
    m_if.in_signed = s;
    m_if.in_a      = a;
    m_if.in_b      = b;
    m_if.in_tag    = tagc;
    e.prod = use_k ? k : ref_mul(16, s, 64'(a), 64'(b));
    e.tag  = tagc;
    e.lat  = lat_mode;
    ok     = 1'b0;
    for (int n = 0; n < 500 && !ok; n++) begin
      @(negedge clk);
      if (m_if.in_ready) begin
        ok    = 1'b1;
        e.acc = cyc;
        q_m.push_back(e);
      end
      @(posedge clk); #1;
    end
    if (!ok) tmo_cnt++;
    tagc = tagc + 4'd1;
  endtask

  task automatic issue_rnd();
    issue(1'($urandom_range(0, 1)), 16'(rnd_op(16)), 16'(rnd_op(16)), 1'b0, 64'd0);
  endtask

  // Idle cycle with junk operands that must not become a result.
  task automatic idle_cycle();
    m_if.in_valid  = 1'b0;
    m_if.in_signed = 1'($urandom_range(0, 1));
    m_if.in_a      = 16'($urandom);
    m_if.in_b      = 16'($urandom);
    m_if.in_tag    = 4'($urandom);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    m_if.in_valid = 1'b0;
    for (int n = 0; n < 200 && q_m.size() != 0; n++) @(posedge clk);
    #1;
  endtask

  initial begin
    m_if.in_valid  = 1'b0;
    m_if.in_signed = 1'b0;
    m_if.in_a      = '0;
    m_if.in_b      = '0;
    m_if.in_tag    = '0;
    m_if.out_ready = 1'b1;
    #1 rst_n = 1'b0;
    rst_sw_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    rst_sw_n = 1'b1;
    idle_cycle();

    // Directed corner products, back to back.
    lat_mode = 1'b1;
    issue(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 64'h0000_0001);
    issue(1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 64'hFFFE_0001);
    issue(1'b1, 16'h8000, 16'h8000, 1'b1, 64'h4000_0000);
    issue(1'b1, 16'h8000, 16'h7FFF, 1'b1, 64'hC000_8000);
    drain();

    // 100-op stream at full rate, tags wrapping 0..15.
    tagc = '0;
    for (int i = 0; i < 100; i++) issue_rnd();
    drain();

    // Backpressure: 5 ops with out_ready held low for 6 cycles.
    lat_mode = 1'b0;
    m_if.out_ready = 1'b0;
    fork
      for (int i = 0; i < 5; i++) issue_rnd();
      begin
        repeat (3) @(posedge clk);
        #1 exp_ir = 2'd1;
        repeat (3) @(posedge clk);
        #1 exp_ir = 2'd0;
        m_if.out_ready = 1'b1;
      end
    join
    drain();

    // Random bubbles on input and random downstream stalls.
    fork
      begin
        for (int n = 0; n < 400; n++) begin
          m_if.out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        m_if.out_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 150; i++) begin
          if ($urandom_range(0, 3) == 0) idle_cycle();
          issue_rnd();
        end
        m_if.in_valid = 1'b0;
      end
    join
    drain();

    // Reset with three operations in flight; only the new op may appear.
    lat_mode = 1'b1;
    m_if.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) issue_rnd();
    m_if.in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_ir = 2'd2;
    issue(1'b1, 16'h0007, 16'hFFFD, 1'b1, 64'hFFFF_FFEB);
    exp_ir = 2'd0;
    drain();
    repeat (4) idle_cycle();

    // Wait for the parameter sweep to finish, bounded.
    for (int n = 0; n < 40000 && !(g_sw[0].done && g_sw[1].done && g_sw[2].done && g_sw[3].done); n++)
      @(posedge clk);
    repeat (8) @(posedge clk);
    #1 fin_req = 1'b1;
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/booth8_mult_pipe.md
Name: booth8_mult_pipe

Overview:
Parametrised, pipelined radix-8 Booth multiplier with valid/ready handshakes at both ends. It is the next generation of the team's combinational 16x16 radix-8 Booth/Wallace multiplier. It adds configurable operand width, a per-transaction signed/unsigned mode, a three-stage pipeline with backpressure, and a sideband tag. It sits between operand-issue logic and a result FIFO in the datapath.

Parameters:
WIDTH, 16, operand width in bits; legal range 4..64.
TAG_W, 4, width of the sideband tag carried alongside each operation.

Ports:
clk  in  1  rising-edge clock; the block's only clock
rst_n  in  1  reset, asynchronous assert, active-low
in_valid  in  1  operand pair valid
in_ready  out  1  block accepts the operands this cycle
in_signed  in  1  1 = signed x signed; 0 = unsigned x unsigned
in_a  in  WIDTH  multiplicand
in_b  in  WIDTH  multiplier
in_tag  in  TAG_W  sideband, returned unchanged with the result
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
out_product  out  2*WIDTH  product, full width, exact
out_tag  out  TAG_W  tag of this result

Behaviour:
- Operands are extended to WIDTH+1 bits: sign-extended when in_signed=1, zero-extended when in_signed=0. They are then padded to the next multiple of 3 above WIDTH+1, with a trailing 0 appended below the LSB. This gives NG = ceil((WIDTH+2)/3) radix-8 Booth groups.
- Recoding: each 4-bit window {b[3i+2:3i], b[3i-1]} maps to a digit in -4..+4. 3*A is formed by one adder in stage 1.
- Partial products: digit*A, sign-extended to 2*WIDTH, two's-complement negation. Each partial product is weighted by 2^(3i).
- Stage S1 registers the NG partial products, the tag and the valid bit.
- Stage S2 reduces the partial products with a 3:2 carry-save tree. Any depth of combinational tree is allowed within S2. S2 registers the sum and carry vectors, the tag and the valid bit.
- Stage S3 performs a carry-propagate add of sum + carry, truncated to 2*WIDTH bits. S3 drives out_product, out_tag and out_valid.
- Latency: 3 cycles from an accepted input to out_valid, with no stalls. Throughput: 1 operation per cycle.
- Handshake: advance = !out_valid | out_ready, and in_ready = advance.
  - An input transfer occurs when in_valid & in_ready.
  - An output transfer occurs when out_valid & out_ready.
  - When advance=0, all stage registers hold, including bubbles. This is a global-stall pipeline; bubbles are not collapsed.
- While out_valid=1 and out_ready=0, out_product and out_tag stay stable until the transfer completes.
- in_ready depends combinationally on out_ready. No other input-to-output combinational paths are allowed.
- Mode: in_signed is captured with its operands. Signed and unsigned operations may be interleaved back-to-back; each result uses its own mode.
- The product is always exact. Signed results lie in [-2^(2W-2)+2^(W-1), 2^(2W-2)]. Unsigned results are at most (2^W-1)^2. Neither range overflows 2*WIDTH.
- Reset, any time including mid-operation: every stage valid bit clears to 0 and out_valid=0. out_product=0 and out_tag=0. In-flight operations are discarded. in_ready=1 in the first cycle after rst_n deasserts.
- Data registers other than the outputs need no reset.
- Inputs while in_valid=0 are don't-care and must not create a valid stage.

Test Plan:
- WIDTH=16, signed: a=0xFFFF, b=0xFFFF -> out_product=0x00000001, three cycles after acceptance.
- WIDTH=16, unsigned: a=0xFFFF, b=0xFFFF -> out_product=0xFFFE0001. Then signed a=0x8000, b=0x8000 -> 0x40000000. Then signed a=0x8000, b=0x7FFF -> 0xC0008000.
- Back-to-back stream: 100 random signed/unsigned pairs with out_ready=1. Required: one result per cycle after the 3-cycle fill, tags 0..15 in order, each product matching a reference model.
- Backpressure: issue 5 operations, hold out_ready=0 for 6 cycles. Required: in_ready=0 after the pipeline fills, out_product/out_tag stable, then 5 results in order with no loss or duplication.
- Reset mid-flight: assert rst_n=0 with 3 operations in flight. Required: out_valid=0 and out_product=0 immediately, none of those results ever appear, and a new operation 7x-3 (signed) returns 0xFFFFFFEB after 3 cycles.
- Parameter sweep WIDTH=4, 8, 13, 32: exhaustive test for WIDTH=4 (both modes, 512 cases). Random 10k cases for the other widths, all exact.
